alu_nzcv_seq: RTL and testbench

//  Registered, handshaked successor of the combinational NZCV ALU: WIDTH-bit operands, 8 ops

---
 rtl/alu_nzcv_pkg.sv | 36 +++
 rtl/alu_nzcv_ext.sv | 61 ++++++
 rtl/alu_nzcv_seq.sv | 151 +++++++++++++++
 tb/tb_alu_nzcv_seq.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_nzcv_pkg.sv
// alu_nzcv_pkg: shared opcode/state enums and NZCV flag bit indices
// for the sequential NZCV ALU (alu_nzcv_seq) and its datapath helper.
package alu_nzcv_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_ADC = 3'b100,
        OP_SBC = 3'b101,
        OP_SHL = 3'b110,
        OP_LSR = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } seq_state_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    function automatic logic [3:0] pack_nzcv(
        input logic n,
        input logic z,
        input logic c,
        input logic v
    );
        return {n, z, c, v};
    endfunction

endpackage

// File: rtl/alu_nzcv_ext.sv
// alu_nzcv_ext: combinational WIDTH-bit ADD/SUB/AND/OR/ADC/SBC with NZCV.
// Ports: i_op opcode, i_a/i_b operands, i_cin carry-in (flags.C),
//        o_res result, o_nzcv {N,Z,C,V}. Opcodes 110/111 pass i_a through.
module alu_nzcv_ext
    import alu_nzcv_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_res,
    output logic [3:0]       o_nzcv
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_res;
    logic             w_c;
    logic             w_v;
    logic             w_sa;
    logic             w_sb;
    logic             w_sr;

    assign w_sa = i_a[WIDTH-1];
    assign w_sb = i_b[WIDTH-1];
    assign w_sr = w_res[WIDTH-1];

    always_comb begin
        w_sum = '0;
        w_res = i_a;
        w_c   = 1'b0;
        w_v   = 1'b0;
        unique case (alu_op_e'(i_op))
            OP_ADD, OP_ADC: begin
                w_sum = {1'b0, i_a} + {1'b0, i_b}
                      + ((WIDTH+1)'(i_op[2] & i_cin));
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (w_sa == w_sb)
                      && (w_sum[WIDTH-1] != w_sa);
            end
            OP_SUB, OP_SBC: begin
                // SUB is SBC with the carry forced to 1 (no borrow in).
                w_sum = {1'b0, i_a} + {1'b0, ~i_b}
                      + ((WIDTH+1)'(i_op[2] ? i_cin : 1'b1));
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (w_sa != w_sb)
                      && (w_sum[WIDTH-1] != w_sa);
            end
            OP_AND: w_res = i_a & i_b;
            OP_OR:  w_res = i_a | i_b;
            default: w_res = i_a;
        endcase
    end

    assign o_res  = w_res;
    assign o_nzcv = pack_nzcv(w_sr, (w_res == '0), w_c, w_v);

endmodule

// File: rtl/alu_nzcv_seq.sv
// alu_nzcv_seq: registered, valid/ready handshaked NZCV ALU, one op in flight.
// Ports: clk, rst_n (async low); in_valid/in_ready, in_op, in_a, in_b,
//        in_flag_we; out_valid/out_ready, out_res, out_nzcv; flags (NZCV reg).
// Define ALU_NZCV_SEQ_SHIFT_EN for multi-cycle SHL/LSR (1 bit per cycle);
// otherwise opcodes 110/111 return operand A with C=V=0 in one cycle.
module alu_nzcv_seq
    import alu_nzcv_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_flag_we,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic [3:0]       out_nzcv,
    output logic [3:0]       flags
);

    seq_state_e       r_state;
    logic             r_valid;
    logic [WIDTH-1:0] r_res;
    logic [3:0]       r_nzcv;
    logic [3:0]       r_flags;

    logic [WIDTH-1:0] w_ext_res;
    logic [3:0]       w_ext_nzcv;
    logic             w_accept;

    alu_nzcv_ext #(
        .WIDTH (WIDTH)
    ) u_ext (
        .i_op   (in_op),
        .i_a    (in_a),
        .i_b    (in_b),
        .i_cin  (r_flags[FLAG_C]),
        .o_res  (w_ext_res),
        .o_nzcv (w_ext_nzcv)
    );

    assign in_ready = (r_state == IDLE) && (!r_valid || out_ready);
    assign w_accept = in_valid && in_ready;

    assign out_valid = r_valid;
    assign out_res   = r_res;
    assign out_nzcv  = r_nzcv;
    assign flags     = r_flags;

`ifdef ALU_NZCV_SEQ_SHIFT_EN

    logic [WIDTH-1:0]   r_sh;
    logic [SHAMT_W-1:0] r_cnt;
    logic               r_lsr;
    logic               r_c;
    logic               r_we;

    logic [SHAMT_W-1:0] w_amt;
    logic               w_is_shift;
    logic [WIDTH-1:0]   w_sh_next;
    logic               w_sh_out;
    logic [3:0]         w_sh_nzcv;

    assign w_amt      = in_b[SHAMT_W-1:0];
    assign w_is_shift = (alu_op_e'(in_op) == OP_SHL)
                     || (alu_op_e'(in_op) == OP_LSR);
    assign w_sh_next  = r_lsr ? (r_sh >> 1) : (r_sh << 1);
    assign w_sh_out   = r_lsr ? r_sh[0] : r_sh[WIDTH-1];
    // r_c holds the bit pushed out by the most recent shift step.
    assign w_sh_nzcv  = pack_nzcv(r_sh[WIDTH-1], (r_sh == '0), r_c, 1'b0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_res   <= '0;
            r_nzcv  <= '0;
            r_flags <= '0;
            r_sh    <= '0;
            r_cnt   <= '0;
            r_lsr   <= 1'b0;
            r_c     <= 1'b0;
            r_we    <= 1'b0;
        end else begin
            if (out_ready) r_valid <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_is_shift && (w_amt != '0)) begin
                            r_state <= SHIFT;
                            r_sh    <= in_a;
                            r_cnt   <= w_amt;
                            r_lsr   <= (alu_op_e'(in_op) == OP_LSR);
                            r_c     <= 1'b0;
                            r_we    <= in_flag_we;
                        end else begin
                            r_res   <= w_ext_res;
                            r_nzcv  <= w_ext_nzcv;
                            r_valid <= 1'b1;
                            if (in_flag_we) r_flags <= w_ext_nzcv;
                        end
                    end
                end
                SHIFT: begin
                    r_sh  <= w_sh_next;
                    r_c   <= w_sh_out;
                    r_cnt <= r_cnt - SHAMT_W'(1);
                    if (r_cnt == SHAMT_W'(1)) r_state <= DONE;
                end
                DONE: begin
                    r_res   <= r_sh;
                    r_nzcv  <= w_sh_nzcv;
                    r_valid <= 1'b1;
                    if (r_we) r_flags <= w_sh_nzcv;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`else

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_res   <= '0;
            r_nzcv  <= '0;
            r_flags <= '0;
        end else begin
            r_state <= IDLE;
            if (out_ready) r_valid <= 1'b0;
            if (w_accept) begin
                r_res   <= w_ext_res;
                r_nzcv  <= w_ext_nzcv;
                r_valid <= 1'b1;
                if (in_flag_we) r_flags <= w_ext_nzcv;
            end
        end
    end

`endif

endmodule

// File: tb/tb_alu_nzcv_seq.sv
// tb_alu_nzcv_seq: directed stimulus for alu_nzcv_seq (WIDTH=4) with an
// arithmetic reference model compared against the outputs every cycle.
module tb_alu_nzcv_seq;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   in_op;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_flag_we;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_res;
    logic [3:0]   out_nzcv;
    logic [3:0]   flags;

    int tests;
    int fails;

    int m_v, m_res, m_nz, m_fl;
    int m_wait, p_res, p_nz, p_we;
    int er, g_r, g_n, g_l;

    alu_nzcv_seq #(
        .WIDTH (W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_flag_we (in_flag_we),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_res    (out_res),
        .out_nzcv   (out_nzcv),
        .flags      (flags)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned/signed values.
    function automatic void golden(input int op, input int a, input int b,
                                   input int cin, output int res,
                                   output int nzcv, output int lat);
        int sa, sb, s, ss, c, v, k;
        c = 0; v = 0; lat = 0; res = a; s = 0; ss = 0;
        sa = (a >= 8) ? a - 16 : a;
        sb = (b >= 8) ? b - 16 : b;
        case (op)
            0: begin s = a + b; ss = sa + sb; end
            1: begin s = a - b + 16; ss = sa - sb; end
            4: begin s = a + b + cin; ss = sa + sb + cin; end
            5: begin s = a + (15 - b) + cin; ss = sa - sb - 1 + cin; end
            default: ;
        endcase
        case (op)
            0, 4, 5: begin
                res = s % 16;
                c = (s >= 16) ? 1 : 0;
                v = (ss > 7 || ss < -8) ? 1 : 0;
            end
            1: begin
                res = s % 16;
                c = (a >= b) ? 1 : 0;
                v = (ss > 7 || ss < -8) ? 1 : 0;
            end
            2: res = a & b;
            3: res = a | b;
            default: begin
`ifdef ALU_NZCV_SEQ_SHIFT_EN
                k = b % 4;
                if (k != 0) begin
                    lat = k + 1;
                    if (op == 6) begin
                        res = (a << k) % 16;
                        c = (a >> (4 - k)) & 1;
                    end else begin
                        res = a >> k;
                        c = (a >> (k - 1)) & 1;
                    end
                end
`else
                k = 0;
                res = a;
`endif
            end
        endcase
        nzcv = ((res >= 8) ? 8 : 0) + ((res == 0) ? 4 : 0) + c * 2 + v;
    endfunction

    // Per-cycle compare against the model, then advance the model by
    // the inputs that the coming rising edge will sample.
    initial begin
        m_v = 0; m_res = 0; m_nz = 0; m_fl = 0;
        m_wait = 0; p_res = 0; p_nz = 0; p_we = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_v = 0; m_res = 0; m_nz = 0; m_fl = 0; m_wait = 0;
            end
            er = (m_wait == 0 && (m_v == 0 || out_ready)) ? 1 : 0;
            chk("in_ready", 8'(in_ready), 8'(er));
            chk("out_valid", 8'(out_valid), 8'(m_v));
            if (m_v != 0) begin
                chk("out_res", 8'(out_res), 8'(m_res));
                chk("out_nzcv", 8'(out_nzcv), 8'(m_nz));
            end
            chk("flags", 8'(flags), 8'(m_fl));
            if (rst_n) begin
                if (m_wait > 0) begin
                    m_wait--;
                    if (m_wait == 0) begin
                        m_v = 1; m_res = p_res; m_nz = p_nz;
                        if (p_we != 0) m_fl = p_nz;
                    end
                end else begin
                    if (m_v != 0 && out_ready) m_v = 0;
                    if (in_valid && er != 0) begin
                        golden(int'(in_op), int'(in_a), int'(in_b),
                               (m_fl >> 1) & 1, g_r, g_n, g_l);
                        if (g_l == 0) begin
                            m_v = 1; m_res = g_r; m_nz = g_n;
                            if (in_flag_we) m_fl = g_n;
                        end else begin
                            m_wait = g_l; p_res = g_r; p_nz = g_n;
                            p_we = int'(in_flag_we);
                        end
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
    endtask

    task automatic issue(input logic [2:0] op, input logic [3:0] a,
                         input logic [3:0] b, input logic we);
        int n;
        logic acc;
        in_op = op; in_a = a; in_b = b; in_flag_we = we;
        in_valid = 1'b1;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 50) begin
            acc = in_ready;
            step();
            n++;
            if (!acc && n >= 2) out_ready = 1'b1;
        end
        if (!acc) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: got no accept expected accept");
        end
        in_valid = 1'b0;
    endtask

    initial begin
        int r, nz, l;
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        in_valid = 1'b0; in_op = 3'd0; in_a = '0; in_b = '0;
        in_flag_we = 1'b0; out_ready = 1'b1;

        golden(0, 7, 1, 0, r, nz, l);
        chk("pin_add", 8'(r * 16 + nz), 8'h89);
        golden(5, 5, 3, 1, r, nz, l);
        chk("pin_sbc1", 8'(r * 16 + nz), 8'h22);
        golden(5, 3, 5, 1, r, nz, l);
        chk("pin_sbc2", 8'(r * 16 + nz), 8'he8);
        golden(1, 8, 1, 0, r, nz, l);
        chk("pin_sub_v", 8'(r * 16 + nz), 8'h73);

        step();
        step();
        chk("rst_valid", 8'(out_valid), 8'h0);
        chk("rst_res", 8'(out_res), 8'h0);
        chk("rst_nzcv", 8'(out_nzcv), 8'h0);
        chk("rst_flags", 8'(flags), 8'h0);
        chk("rst_ready", 8'(in_ready), 8'h1);
        rst_n = 1'b1;
        step();

        issue(3'b000, 4'h7, 4'h1, 1'b1);
        chk("add_res", 8'(out_res), 8'h8);
        chk("add_nzcv", 8'(out_nzcv), 8'h9);
        chk("add_flags", 8'(flags), 8'h9);

        issue(3'b001, 4'h3, 4'h3, 1'b0);
        chk("sub_res", 8'(out_res), 8'h0);
        chk("sub_nzcv", 8'(out_nzcv), 8'h6);
        chk("sub_flags", 8'(flags), 8'h9);

        issue(3'b000, 4'hf, 4'h1, 1'b1);
        chk("addc_res", 8'(out_res), 8'h0);
        chk("addc_nzcv", 8'(out_nzcv), 8'h6);
        issue(3'b100, 4'h0, 4'h0, 1'b1);
        chk("adc_res", 8'(out_res), 8'h1);
        chk("adc_nzcv", 8'(out_nzcv), 8'h0);
        chk("adc_flags", 8'(flags), 8'h0);

        idle();
        out_ready = 1'b0;
        issue(3'b000, 4'h2, 4'h3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_res", 8'(out_res), 8'h5);
            chk("hold_nzcv", 8'(out_nzcv), 8'h0);
            chk("hold_ready", 8'(in_ready), 8'h0);
        end
        out_ready = 1'b1;
        #1;
        chk("pop_ready", 8'(in_ready), 8'h1);
        step();
        chk("pop_valid", 8'(out_valid), 8'h0);

`ifdef ALU_NZCV_SEQ_SHIFT_EN
        issue(3'b110, 4'h9, 4'h1, 1'b1);
        chk("shl_busy", 8'(out_valid), 8'h0);
        step();
        chk("shl_busy2", 8'(out_valid), 8'h0);
        step();
        chk("shl_valid", 8'(out_valid), 8'h1);
        chk("shl_res", 8'(out_res), 8'h2);
        chk("shl_nzcv", 8'(out_nzcv), 8'h2);
        issue(3'b110, 4'h9, 4'h0, 1'b0);
        chk("shl0_res", 8'(out_res), 8'h9);
        chk("shl0_nzcv", 8'(out_nzcv), 8'h8);
        chk("shl0_flags", 8'(flags), 8'h2);
        issue(3'b110, 4'h1, 4'h3, 1'b1);
        step();
`else
        issue(3'b110, 4'h9, 4'h1, 1'b1);
        chk("shl_res", 8'(out_res), 8'h9);
        chk("shl_nzcv", 8'(out_nzcv), 8'h8);
        issue(3'b111, 4'h4, 4'h2, 1'b0);
        chk("lsr_res", 8'(out_res), 8'h4);
        chk("lsr_flags", 8'(flags), 8'h8);
`endif
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", 8'(out_valid), 8'h0);
        chk("mrst_flags", 8'(flags), 8'h0);
        step();
        rst_n = 1'b1;
        issue(3'b000, 4'h4, 4'h4, 1'b1);
        chk("post_res", 8'(out_res), 8'h8);
        chk("post_nzcv", 8'(out_nzcv), 8'h9);
        chk("post_flags", 8'(flags), 8'h9);

        for (int i = 0; i < 32; i++) begin
            out_ready = (i % 3 != 0);
            issue(3'(i % 8), 4'((i * 5 + 3) % 16), 4'((i * 7 + 1) % 16),
                  1'(i % 2));
        end
        idle();
        idle();
        for (int i = 0; i < 6; i++) idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
